// File: rtl/dac_cap_pkg.sv
// Shared types and constants for the DAC capture buffer.
package dac_cap_pkg;

    localparam int DAC_W     = 13;
    localparam int DEF_DEPTH = 256;
    localparam int DEF_HOLD  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_HOLDOFF,
        ST_READOUT
    } cap_state_e;

endpackage

// File: rtl/dac_cap_ram.sv
// Capture storage: one write port, one registered read port, no reset.
// rd_data holds its value on cycles where rd_en is low.
module dac_cap_ram
    import dac_cap_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DAC_W
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port, one cycle of latency.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/dac_capture_buf.sv
// DAC capture buffer: records DAC words on dac_en rising edges inside a
// store_strb window (plus a hold-off tail), then streams them out.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | waiting for arm; results of last capture stay readable
//   ST_ARMED   | waiting for a store_strb rising edge
//   ST_CAPTURE | store_strb high, dac_en edges write the RAM
//   ST_HOLDOFF | store_strb low, capture continues for HOLD cycles
//   ST_READOUT | words 0..cap_count-1 streamed on rd_*
module dac_capture_buf
    import dac_cap_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int HOLD  = DEF_HOLD
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      arm,
    input  logic                      abort,
    input  logic                      store_strb,
    input  logic signed [DAC_W-1:0]   dac_din,
    input  logic                      dac_en,
    input  logic                      oflow_in,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [DAC_W-1:0]          rd_data,
    output logic                      rd_last,
    output logic                      busy,
    output logic                      done,
    output logic                      full,
    output logic                      oflow_seen,
    output logic [$clog2(DEPTH):0]    cap_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = $clog2(HOLD + 1);

    cap_state_e        state, state_nxt;
    logic              done_nxt;
    logic              strb_q, en_q;
    logic              strb_rise, en_rise;
    logic              capturing;
    logic              wr_en;
    logic [HW-1:0]     hold_cnt;

    logic [CW-1:0]     fetch_ptr;
    logic              ram_vld;
    logic              ram_last;
    logic              ram_re;
    logic [DAC_W-1:0]  ram_rdata;
    logic              move;
    logic              xfer;

    assign strb_rise = store_strb & ~strb_q;
    assign en_rise   = dac_en & ~en_q;
    assign capturing = (state == ST_CAPTURE) || (state == ST_HOLDOFF);
    // cap_count never exceeds DEPTH, so its MSB alone marks a full buffer.
    assign full      = cap_count[CW-1];
    assign wr_en     = capturing & en_rise & ~full & ~abort;
    assign busy      = (state != ST_IDLE);

    // Readout handshake: the RAM output slot drains into the output register
    // whenever that register is empty or being consumed this cycle.
    assign xfer   = rd_valid & rd_ready;
    assign move   = ram_vld & (~rd_valid | rd_ready);
    assign ram_re = (state == ST_READOUT) & ~abort & (fetch_ptr < cap_count) & (~ram_vld | move);

    dac_cap_ram #(
        .DEPTH (DEPTH),
        .WIDTH (DAC_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (cap_count[AW-1:0]),
        .wr_data (dac_din),
        .rd_en   (ram_re),
        .rd_addr (fetch_ptr[AW-1:0]),
        .rd_data (ram_rdata)
    );

    // State register and one-cycle done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
        end
    end

    // Next-state logic; abort overrides everything and never produces done.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arm) state_nxt = ST_ARMED;
                end
                ST_ARMED: begin
                    if (strb_rise) state_nxt = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (full)             state_nxt = ST_READOUT;
                    else if (!store_strb) state_nxt = ST_HOLDOFF;
                end
                ST_HOLDOFF: begin
                    if (full || hold_cnt == '0) state_nxt = ST_READOUT;
                end
                ST_READOUT: begin
                    if (cap_count == '0 || (xfer && rd_last)) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Edge history, capture counter, sticky overflow flag and hold-off timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strb_q     <= 1'b0;
            en_q       <= 1'b0;
            cap_count  <= '0;
            oflow_seen <= 1'b0;
            hold_cnt   <= '0;
        end else begin
            strb_q <= store_strb;
            en_q   <= dac_en;
            if (state == ST_ARMED && state_nxt == ST_CAPTURE) begin
                cap_count  <= '0;
                oflow_seen <= 1'b0;
            end else begin
                if (wr_en)                 cap_count  <= cap_count + 1'b1;
                if (capturing && oflow_in) oflow_seen <= 1'b1;
            end
            // Reloaded throughout CAPTURE so HOLDOFF starts from HOLD-1.
            if (state == ST_CAPTURE) begin
                hold_cnt <= HW'(HOLD - 1);
            end else if (state == ST_HOLDOFF && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

    // Read-ahead pipeline: RAM fetch pointer, RAM output slot, output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_ptr <= '0;
            ram_vld   <= 1'b0;
            ram_last  <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_last   <= 1'b0;
        end else if (state != ST_READOUT || abort) begin
            fetch_ptr <= '0;
            ram_vld   <= 1'b0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
        end else begin
            if (ram_re) begin
                fetch_ptr <= fetch_ptr + 1'b1;
                ram_last  <= (fetch_ptr == cap_count - 1'b1);
                ram_vld   <= 1'b1;
            end else if (move) begin
                ram_vld   <= 1'b0;
            end
            if (move) begin
                rd_valid <= 1'b1;
                rd_data  <= ram_rdata;
                rd_last  <= ram_last;
            end else if (xfer) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/dac_capture_buf.md
DAC_CAPTURE_BUF -- requirements
Module: dac_capture_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of capture words (power of 2, 16..1024).
REQ-002 SHALL have parameter HOLD, default 16, cycles the capture window stays open after store_strb falls.
REQ-003 SHALL have port clk, in, 1, single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, in, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port arm, in, 1, single-cycle request to arm a capture.
REQ-006 SHALL have port abort, in, 1, forces return to IDLE.
REQ-007 SHALL have port store_strb, in, 1, pulse window strobe.
REQ-008 SHALL have port dac_din, in, 13 (signed), DAC word from the amp drive stage.
REQ-009 SHALL have port dac_en, in, 1, DAC clock/enable from the amp drive stage.
REQ-010 SHALL have port oflow_in, in, 1, filter overflow flag from the amp drive stage.
REQ-011 SHALL have ports rd_valid out 1, rd_ready in 1, rd_data out 13, rd_last out 1: readout stream.
REQ-012 SHALL have ports busy out 1, done out 1 (one-cycle pulse), full out 1, oflow_seen out 1, cap_count out log2(DEPTH)+1.

Function
REQ-013 SHALL implement states IDLE, ARMED, CAPTURE, HOLDOFF, READOUT.
REQ-014 IDLE->ARMED on arm=1; arm in any other state SHALL be ignored.
REQ-015 ARMED->CAPTURE on store_strb rising edge (store_strb=1, previous cycle 0); cap_count, full and oflow_seen SHALL clear on that transition.
REQ-016 In CAPTURE/HOLDOFF, a dac_en rising edge SHALL write dac_din of that same cycle to address cap_count and increment cap_count.
REQ-017 CAPTURE->HOLDOFF when store_strb=0; HOLDOFF SHALL last exactly HOLD cycles, then go to READOUT. A store_strb rising edge in HOLDOFF SHALL NOT restart capture.
REQ-018 When cap_count reaches DEPTH, full SHALL assert, further dac_en edges SHALL be dropped (no wrap), and the FSM SHALL go to READOUT on the next cycle.
REQ-019 oflow_in=1 during CAPTURE/HOLDOFF SHALL set sticky oflow_seen until the next capture start or reset.
REQ-020 READOUT SHALL present words 0..cap_count-1 in order; rd_valid rises no later than 2 cycles after entry; rd_data/rd_last SHALL stay stable while rd_valid=1 and rd_ready=0.
REQ-021 A word transfers when rd_valid=1 and rd_ready=1; throughput SHALL be one word per cycle with rd_ready held high.
REQ-022 rd_last SHALL be 1 only with the final word; after its transfer FSM SHALL go to IDLE and pulse done for one cycle.
REQ-023 READOUT with cap_count=0 SHALL never assert rd_valid, SHALL go to IDLE and pulse done.
REQ-024 abort=1 in any state SHALL go to IDLE next cycle, deassert rd_valid, no done pulse; abort wins over simultaneous arm.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 cap_count, full, oflow_seen SHALL stay readable and unchanged in IDLE until the next capture start.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, rd_valid=0, rd_last=0, rd_data=0, done=0, busy=0, full=0, oflow_seen=0, cap_count=0.
REQ-028 Reset mid-capture or mid-readout SHALL discard the capture; RAM contents need not be cleared.
REQ-029 Edge-detect history registers SHALL reset to 0, so store_strb or dac_en high at reset release SHALL NOT count as an edge.

Structure
REQ-030 Package dac_cap_pkg SHALL hold the state enumeration, DAC word width (13) and default DEPTH/HOLD constants.
REQ-031 Storage SHALL be sub-module dac_cap_ram: simple dual-port, one write port, one registered read port (1-cycle latency), no reset.
REQ-032 Read-ahead register(s) SHALL hide RAM latency to meet REQ-021.

Verification
REQ-033 arm; store_strb high 40 cycles; dac_en toggling every cycle, dac_din=0,1,2,... at rising edges; rd_ready=1 -> 20 words 0..19, rd_last on 19, done one cycle after.
REQ-034 DEPTH=16; store_strb high 100 cycles with dac_en toggling -> full=1, cap_count=16, words 0..15, later edges dropped.
REQ-035 Readout with rd_ready toggling 1,0,0,1,... -> no word lost or duplicated; rd_data stable while stalled.
REQ-036 arm; store_strb pulse with dac_en=0 throughout -> cap_count=0, rd_valid never high, done pulses after HOLD cycles.
REQ-037 oflow_in pulsed 1 cycle mid-capture -> oflow_seen=1 through readout and IDLE, cleared at next capture start.
REQ-038 rst_n low mid-capture, then abort+arm together in ARMED -> all outputs at reset values; abort wins, state IDLE, no done.
